folded_threshold_vote: RTL and testbench

- Sequential, parametrised successor to the flat N-input majority gate.
- Consumes an N-bit vote vector as W-bit chunks over a valid/ready stream and accumulates the popcount.
- Compares the count against a per-frame threshold and emits one registered result per frame, with count and early-decision flag.
- Used as the folded, area-reduced replacement for wide majority/threshold gates (default 51-input majority) in the bias-decomposition datapath.

---
 rtl/folded_threshold_vote.sv | 142 ++++++++++++++
 tb/tb_folded_threshold_vote.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/folded_threshold_vote.sv
// Folded threshold/majority vote: accumulates the popcount of an N-bit vote vector
// streamed in CHUNK_W-bit beats and emits one registered decision per frame.
module folded_threshold_vote #(
  parameter int N_INPUTS = 51,
  parameter int CHUNK_W  = 8,
  parameter int DEF_THR  = (N_INPUTS + 1) / 2,
  localparam int NCH     = (N_INPUTS + CHUNK_W - 1) / CHUNK_W,
  localparam int CW      = $clog2(N_INPUTS + 2),
  localparam int LAST_W  = N_INPUTS - (NCH - 1) * CHUNK_W,
  localparam int IW      = $clog2(NCH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [CHUNK_W-1:0] in_data,
  input  logic               thr_override,
  input  logic [CW-1:0]      thr_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_y,
  output logic [CW-1:0]      out_count,
  output logic               out_early,
  output logic [IW-1:0]      out_chunk_idx
);

  localparam logic [IW-1:0] LAST_IDX  = IW'(NCH - 1);
  localparam logic [CW-1:0] DEF_THR_C = CW'(DEF_THR);

  typedef enum logic {ST_ACC, ST_OUT} state_t;

  state_t state_reg, state_next;

  logic [CW-1:0]      acc_reg;
  logic [IW-1:0]      idx_reg;
  logic               early_reg;
  logic [CW-1:0]      thr_reg;
  logic               out_y_reg;
  logic [CW-1:0]      out_count_reg;
  logic               out_early_reg;

  logic               accept;
  logic               first_beat;
  logic               last_beat;
  logic [CHUNK_W-1:0] vote_mask;
  logic [CHUNK_W-1:0] masked_votes;
  logic [CW-1:0]      pop;
  logic [CW-1:0]      thr_eff;
  logic [CW-1:0]      acc_next;
  int                 remaining_bits;
  logic               early_hit;

  assign first_beat = (idx_reg == '0);
  assign last_beat  = (idx_reg == LAST_IDX);

  // Bits above LAST_W on the final beat are not votes and must never be counted.
  for (genvar gi = 0; gi < CHUNK_W; gi++) begin : g_mask
    if (gi < LAST_W) begin : g_full
      assign vote_mask[gi] = 1'b1;
    end else begin : g_tail
      assign vote_mask[gi] = ~last_beat;
    end
  end

  assign masked_votes = in_data & vote_mask;

  always_comb begin
    pop = '0;
    for (int i = 0; i < CHUNK_W; i++) begin
      pop = pop + CW'(masked_votes[i]);
    end
  end

  // The threshold is captured on the first beat; later beats use the latched copy.
  assign thr_eff  = first_beat ? (thr_override ? thr_in : DEF_THR_C) : thr_reg;
  assign acc_next = (first_beat ? '0 : acc_reg) + pop;

  always_comb begin
    remaining_bits = N_INPUTS - (int'(idx_reg) + 1) * CHUNK_W;
    early_hit = 1'b0;
    if (!last_beat) begin
      early_hit = (acc_next >= thr_eff) ||
                  ((int'(acc_next) + remaining_bits) < int'(thr_eff));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_reg <= ST_ACC;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state_reg)
      ST_ACC: begin
        in_ready = 1'b1;
        if (in_valid && last_beat) state_next = ST_OUT;
      end
      ST_OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_next = ST_ACC;
      end
      default: state_next = ST_ACC;
    endcase
  end

  assign accept = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_reg       <= '0;
      idx_reg       <= '0;
      early_reg     <= 1'b0;
      thr_reg       <= '0;
      out_y_reg     <= 1'b0;
      out_count_reg <= '0;
      out_early_reg <= 1'b0;
    end else if (accept) begin
      acc_reg   <= acc_next;
      thr_reg   <= thr_eff;
      idx_reg   <= idx_reg + 1'b1;
      early_reg <= early_reg | early_hit;
      if (last_beat) begin
        out_count_reg <= acc_next;
        out_y_reg     <= (acc_next >= thr_eff);
        out_early_reg <= early_reg;
      end
    end else if (out_valid && out_ready) begin
      acc_reg   <= '0;
      idx_reg   <= '0;
      early_reg <= 1'b0;
    end
  end

  assign out_y         = out_y_reg;
  assign out_count     = out_count_reg;
  assign out_early     = out_early_reg;
  assign out_chunk_idx = idx_reg;

endmodule

// File: tb/tb_folded_threshold_vote.sv
// Scoreboard bench for folded_threshold_vote: a driver pushes expected results
// computed from the vote bits, a monitor pops and compares on each presented result.
module tb_folded_threshold_vote;

  localparam int N       = 51;
  localparam int W       = 8;
  localparam int NCH     = 7;
  localparam int CW      = 6;
  localparam int IW      = 3;
  localparam int PW      = NCH * W;
  localparam int DEF_THR = 26;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          thr_override;
  logic [CW-1:0] thr_in;
  logic          out_valid;
  logic          out_ready;
  logic          out_y;
  logic [CW-1:0] out_count;
  logic          out_early;
  logic [IW-1:0] out_chunk_idx;

  always #5 clk = ~clk;

  folded_threshold_vote #(.N_INPUTS(N), .CHUNK_W(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .thr_override(thr_override), .thr_in(thr_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_y(out_y), .out_count(out_count), .out_early(out_early),
    .out_chunk_idx(out_chunk_idx)
  );

  typedef struct {
    logic y;
    int   count;
    logic early;
    int   stall;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   mon_busy = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: count votes, then test each non-final beat boundary for an early decision.
  function automatic exp_t model(input logic [PW-1:0] bits, input int thr, input int stall);
    exp_t e;
    int total;
    int s;
    total = 0;
    for (int i = 0; i < N; i++) total += int'(bits[i]);
    e.count = total;
    e.y     = (total >= thr);
    e.early = 1'b0;
    e.stall = stall;
    for (int k = 0; k < NCH - 1; k++) begin
      s = 0;
      for (int i = 0; i < (k + 1) * W; i++) s += int'(bits[i]);
      if (s >= thr || s + (N - (k + 1) * W) < thr) e.early = 1'b1;
    end
    return e;
  endfunction

  // Starts and ends on a falling edge. abort_at>0 resets after that many beats.
  task automatic send_frame(input logic [PW-1:0] bits, input logic ovr,
                            input logic [CW-1:0] thr, input int stall, input int abort_at);
    int thr_used;
    int t;
    thr_used = ovr ? int'(thr) : DEF_THR;
    if (abort_at == 0) exp_q.push_back(model(bits, thr_used, stall));
    for (int b = 0; b < NCH; b++) begin
      if (abort_at != 0 && b == abort_at) break;
      repeat ($urandom_range(0, 2)) begin
        in_valid = 1'b0;
        in_data  = W'($urandom());
        @(negedge clk);
      end
      in_valid = 1'b1;
      in_data  = bits[b*W +: W];
      if (b == 0) begin
        thr_override = ovr;
        thr_in       = thr;
      end else begin
        thr_override = 1'($urandom());
        thr_in       = CW'($urandom());
      end
      t = 0;
      while (!in_ready && t < 200) begin
        @(negedge clk);
        t++;
      end
      if (t >= 200) begin
        n_checks++;
        n_fail++;
        $display("FAIL in_ready timeout: got 0, expected 1 within 200 cycles");
      end
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = W'($urandom());
      if (b == NCH - 1) check("latency out_valid", 32'(out_valid), 32'd1);
    end
    if (abort_at != 0) begin
      check("idx before reset", 32'(out_chunk_idx), 32'(abort_at));
      rst = 1'b1;
      @(negedge clk);
      check("reset out_valid", 32'(out_valid), 32'd0);
      check("reset chunk_idx", 32'(out_chunk_idx), 32'd0);
      check("reset in_ready", 32'(in_ready), 32'd1);
      rst = 1'b0;
    end
  endtask

  initial begin : monitor
    exp_t cur;
    bit   post_chk;
    int   stall_left;
    post_chk   = 1'b0;
    stall_left = 0;
    out_ready  = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        out_ready = 1'b0;
        post_chk  = 1'b0;
        continue;
      end
      if (post_chk) begin
        check("in_ready after release", 32'(in_ready), 32'd1);
        check("out_valid after release", 32'(out_valid), 32'd0);
        post_chk = 1'b0;
      end
      if (out_valid) begin
        if (!mon_busy) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected result: got count %0d, expected no result", out_count);
            out_ready = 1'b1;
            continue;
          end
          cur        = exp_q.pop_front();
          mon_busy   = 1'b1;
          stall_left = cur.stall;
        end
        check("out_count", 32'(out_count), 32'(cur.count));
        check("out_y", 32'(out_y), 32'(cur.y));
        check("out_early", 32'(out_early), 32'(cur.early));
        check("in_ready in OUT", 32'(in_ready), 32'd0);
        if (stall_left > 0) begin
          out_ready = 1'b0;
          stall_left--;
        end else begin
          out_ready = ($urandom_range(0, 2) != 0);
        end
        if (out_ready) begin
          mon_busy = 1'b0;
          post_chk = 1'b1;
        end
      end else begin
        out_ready = 1'($urandom());
      end
    end
  end

  initial begin : driver
    logic [PW-1:0] bits;
    int t;
    rst          = 1'b1;
    in_valid     = 1'b0;
    in_data      = '0;
    thr_override = 1'b0;
    thr_in       = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst in_ready", 32'(in_ready), 32'd1);
    check("rst out_count", 32'(out_count), 32'd0);
    check("rst out_y", 32'(out_y), 32'd0);
    check("rst out_early", 32'(out_early), 32'd0);
    check("rst chunk_idx", 32'(out_chunk_idx), 32'd0);

    // All ones including the ignored tail bits.
    bits = '1;
    send_frame(bits, 1'b0, '0, 0, 0);

    // Exactly 26 ones spread over the frame, then 25.
    bits = '0;
    for (int i = 0; i < N; i++) bits[i] = ((i * 26) % 51 < 26);
    send_frame(bits, 1'b0, '0, 0, 0);
    for (int i = 0; i < N; i++) begin
      if (bits[i]) begin
        bits[i] = 1'b0;
        break;
      end
    end
    send_frame(bits, 1'b0, '0, 0, 0);

    // Only ignored tail bits set.
    bits = '0;
    for (int i = N; i < PW; i++) bits[i] = 1'b1;
    send_frame(bits, 1'b0, '0, 0, 0);

    // Threshold extremes.
    bits = '0;
    send_frame(bits, 1'b1, CW'(0), 0, 0);
    bits = '1;
    send_frame(bits, 1'b1, CW'(52), 0, 0);

    // Consumer back-pressure for 5 cycles.
    bits = PW'({$urandom(), $urandom()});
    send_frame(bits, 1'b0, '0, 5, 0);

    // Mid-frame reset, then an independent full frame.
    bits = PW'({$urandom(), $urandom()});
    send_frame(bits, 1'b0, '0, 0, 3);
    bits = PW'({$urandom(), $urandom()});
    send_frame(bits, 1'b0, '0, 0, 0);

    for (int f = 0; f < 40; f++) begin
      bits = PW'({$urandom(), $urandom()});
      send_frame(bits, 1'($urandom()), CW'($urandom()), $urandom_range(0, 3), 0);
    end

    t = 0;
    while ((exp_q.size() != 0 || mon_busy) && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: got %0d results pending, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
